memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Shares one single-ported RAM between four requesters: icache and dcache of core 0 and core 1.
- Fixed priority across request types (data before instruction); round-robin between cores.
- Holds one LL/SC reservation per core, so atomic load-linked/store-conditional operations from each datapath resolve correctly.
- Sits between the per-core caches and the RAM model, and replaces the direct cache-to-RAM hookup.

Parameters:
ADDR_W, 32, address and data width (word_t)
CORES, 2, number of cores (fixed at 2; requester index = {core, isData})

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-high (1 = reset); port name kept for consistency
iREN  in  2  per-core instruction read request
iaddr  in  2x32  per-core instruction address
dREN  in  2  per-core data read request
dWEN  in  2  per-core data write request
datomic  in  2  per-core atomic qualifier (LL when dREN, SC when dWEN)
daddr  in  2x32  per-core data address
dstore  in  2x32  per-core store data
iwait  out  2  1 = instruction request not complete
dwait  out  2  1 = data request not complete
iload  out  2x32  instruction word, valid when iwait low
dload  out  2x32  load data, or SC result (1 success / 0 fail), valid when dwait low
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- States: IDLE, SERVE, SCFAIL. Registers: state, grant[1:0] ({core,isData}), last_core, link_valid[2], link_addr[2].
- Reset (asynchronous, mid-operation allowed): state=IDLE, last_core=1 (so core 0 wins first), link_valid=0, link_addr=0, grant=0. Outstanding access is aborted.
- Outputs in IDLE and SCFAIL: ramREN=ramWEN=0, ramaddr=ramstore=0. iwait and dwait are 1 for every requester, except as noted for SCFAIL.
- Requesters hold address, data and enables stable while their wait output is 1.
- IDLE selection, with data = dREN|dWEN:
  - Candidate core: if both cores have requests, the core != last_core; otherwise the requesting core.
  - Within that core, data beats instruction.
  - Any data request from either core beats all instruction requests, with round-robin applied among data requests first.
- Next state from IDLE:
  - Granted SC whose reservation fails (link_valid[c]=0 or link_addr[c]!=daddr[c]): go to SCFAIL.
  - Any other granted request: go to SERVE.
  - Update last_core to the granted core.
- SERVE:
  - Drive ramaddr/ramREN/ramWEN/ramstore combinationally from the granted requester.
  - BUSY, FREE, ERROR: hold (ERROR is retried).
  - ACCESS: drop the granted wait to 0 for exactly this cycle. Drive iload/dload = ramload; an SC drives dload = 1. Return to IDLE.
  - Latency: minimum 2 cycles from request to wait low (1 arbitration cycle + RAM). There is one idle bubble between grants.
- SCFAIL: dwait[c]=0 and dload[c]=0 for one cycle, no RAM access, then IDLE.
- Reservations, evaluated on ACCESS:
  - LL by core c: link_valid[c]=1, link_addr[c]=daddr[c].
  - Any write completing from core k (plain or SC) to address A clears link_valid[j] for every core j with link_addr[j]==A, including k itself.
  - Successful SC also clears its own link.
  - If an LL and a clear target the same register in the same cycle, the LL set wins.
- iload/dload are 0 whenever the corresponding wait is 1.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR), arb_state_t (IDLE/SERVE/SCFAIL).
- Sub-module rr_select: given request vectors and last_core, returns grant index and valid (combinational).
- The FSM and the link registers stay in memory_arbiter.

Test Plan:
- Core0 iREN, iaddr=0x100; RAM gives ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF. Required: iwait[0] low exactly one cycle, 4 cycles after request; iload[0]=0xDEADBEEF.
- Core0 iREN and dREN together. Required: data served first (ramaddr=daddr[0]), then instruction after one IDLE bubble.
- Both cores dREN continuously. Required: grants alternate core0, core1, core0… and no core starves.
- Core0 LL 0x200, then SC 0x200 with dstore=5. Required: ramWEN with ramstore=5; dload[0]=1; link_valid[0]=0 afterwards.
- Core0 LL 0x200, core1 SW 0x200, core0 SC 0x200. Required: SC goes through SCFAIL; dload[0]=0; no ramWEN for the SC.
- Assert nRST during SERVE with ramstate=BUSY. Required: ramREN/ramWEN drop immediately (asynchronously); all waits=1; links cleared; after release, core0 is granted first.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-core memory arbiter: RAM handshake states, arbiter FSM states
// and the round-robin core pick used by the selector.
package memory_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CORES  = 2;

  typedef logic [ADDR_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    SCFAIL = 2'd2
  } arb_state_t;

  // With both cores asking, the one not served last wins; otherwise the lone requester.
  function automatic logic pick_core(input logic [1:0] req, input logic last_core);
    return (&req) ? ~last_core : req[1];
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side request/response bus plus the RAM-side port of the memory arbiter.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic [1:0]             iREN;
  logic [1:0][ADDR_W-1:0] iaddr;
  logic [1:0]             dREN;
  logic [1:0]             dWEN;
  logic [1:0]             datomic;
  logic [1:0][ADDR_W-1:0] daddr;
  logic [1:0][ADDR_W-1:0] dstore;
  logic [1:0]             iwait;
  logic [1:0]             dwait;
  logic [1:0][ADDR_W-1:0] iload;
  logic [1:0][ADDR_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  word_t                  ramaddr;
  word_t                  ramstore;
  word_t                  ramload;
  ramstate_t              ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_rr_select.sv
// Combinational requester pick: data beats instruction, round-robin between cores.
module memory_arbiter_rr_select
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] data_req,
  input  logic [1:0] inst_req,
  input  logic       last_core,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    grant = 2'b00;
    valid = 1'b0;
    if (|data_req) begin
      grant = {pick_core(data_req, last_core), 1'b1};
      valid = 1'b1;
    end else if (|inst_req) begin
      grant = {pick_core(inst_req, last_core), 1'b0};
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between the I/D caches of two cores and tracks one
// LL/SC reservation per core.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  memory_arbiter_if.slave bus
);

  arb_state_t state;
  logic [1:0] grant;
  logic       last_core;
  logic [1:0] link_valid;
  word_t      link_addr [CORES];

  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_core;
  logic       sel_sc;
  logic       link_ok;

  logic       g_core;
  logic       g_data;
  logic       g_write;
  logic       g_atomic;
  word_t      g_addr;

  memory_arbiter_rr_select u_rr_select (
    .data_req  (bus.dREN | bus.dWEN),
    .inst_req  (bus.iREN),
    .last_core (last_core),
    .grant     (sel),
    .valid     (sel_valid)
  );

  assign sel_core = sel[1];
  assign sel_sc   = sel[0] & bus.dWEN[sel_core] & bus.datomic[sel_core];
  assign link_ok  = link_valid[sel_core] && (link_addr[sel_core] == bus.daddr[sel_core]);

  assign g_core   = grant[1];
  assign g_data   = grant[0];
  assign g_write  = g_data & bus.dWEN[g_core];
  assign g_atomic = g_data & bus.datomic[g_core];
  assign g_addr   = g_data ? bus.daddr[g_core] : bus.iaddr[g_core];

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 2'b11;
    bus.dwait    = 2'b11;
    bus.iload    = '0;
    bus.dload    = '0;
    if (state == SERVE) begin
      bus.ramaddr  = g_addr;
      bus.ramWEN   = g_write;
      bus.ramREN   = ~g_write;
      bus.ramstore = g_write ? bus.dstore[g_core] : '0;
      if (bus.ramstate == ACCESS) begin
        if (g_data) begin
          bus.dwait[g_core] = 1'b0;
          // A completing SC reports success instead of RAM data.
          bus.dload[g_core] = (g_write && g_atomic) ? word_t'(1) : bus.ramload;
        end else begin
          bus.iwait[g_core] = 1'b0;
          bus.iload[g_core] = bus.ramload;
        end
      end
    end else if (state == SCFAIL) begin
      bus.dwait[g_core] = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_core  <= 1'b1;
      link_valid <= 2'b00;
      for (int unsigned j = 0; j < CORES; j++) link_addr[j] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_valid) begin
            grant     <= sel;
            last_core <= sel_core;
            state     <= (sel_sc && !link_ok) ? SCFAIL : SERVE;
          end
        end
        SERVE: begin
          if (bus.ramstate == ACCESS) begin
            state <= IDLE;
            if (g_write) begin
              for (int unsigned j = 0; j < CORES; j++) begin
                if (link_addr[j] == g_addr) link_valid[j] <= 1'b0;
              end
              if (g_atomic) link_valid[g_core] <= 1'b0;
            end
            // Placed last so a load-linked set overrides a same-cycle clear.
            if (g_data && !g_write && g_atomic) begin
              link_valid[g_core] <= 1'b1;
              link_addr[g_core]  <= g_addr;
            end
          end
        end
        SCFAIL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
